// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the scratch RAM.
// The slave view belongs to the arbiter; the master view is the opposite side
// (requesters plus the RAM's read-data return).
interface ram_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_data;
    logic              ram_read;
    logic              ram_write;
    logic              ram_ena;
    logic              busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_data,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata,
        output ram_addr, ram_din, ram_read, ram_write, ram_ena, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_data,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata,
        input  ram_addr, ram_din, ram_read, ram_write, ram_ena, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the 4-entry scratch
// RAM. Every output is a flop; the combinational block computes the value each
// output takes in the next state, so outputs line up with the registered state.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | sample requests, grant, latch command or reject bad address
// SETUP  | addr/din/strobe driven, ram_ena still high (setup time)
// STROBE | ram_ena low for ACCESS_CYCLES cycles, read data captured at end
// DONE   | ram_ena high, strobes low, ack (and err) to granted master
module ram_arbiter #(
    parameter int ADDR_W        = 6,
    parameter int DATA_W        = 8,
    parameter int DEPTH         = 4,
    parameter int ACCESS_CYCLES = 1   // legal 1..4, held in a 2-bit counter
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        cnt, cnt_nx;
    logic              gnt, gnt_nx;
    logic              we_q, we_nx;
    logic              last_grant, last_nx;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_nx;
    logic [DATA_W-1:0] ram_din_q, ram_din_nx;
    logic              ram_read_q, ram_read_nx;
    logic              ram_write_q, ram_write_nx;
    logic              ram_ena_q, ram_ena_nx;
    logic              ack0_q, ack0_nx, ack1_q, ack1_nx;
    logic              err0_q, err0_nx, err1_q, err1_nx;
    logic [DATA_W-1:0] rdata0_q, rdata0_nx, rdata1_q, rdata1_nx;
    logic              busy_q;

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ok;

    // Grant choice: a lone requester wins, contention goes to the master that
    // was not served last.
    always_comb begin
        pick      = (bus.m0_req && bus.m1_req) ? ~last_grant : bus.m1_req;
        sel_we    = pick ? bus.m1_we    : bus.m0_we;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
        sel_ok    = sel_addr < ADDR_W'(DEPTH);
    end

    // Next-state and next-output values.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        gnt_nx       = gnt;
        we_nx        = we_q;
        last_nx      = last_grant;
        ram_addr_nx  = ram_addr_q;
        ram_din_nx   = ram_din_q;
        ram_read_nx  = ram_read_q;
        ram_write_nx = ram_write_q;
        ram_ena_nx   = 1'b1;
        ack0_nx      = 1'b0;
        ack1_nx      = 1'b0;
        err0_nx      = 1'b0;
        err1_nx      = 1'b0;
        rdata0_nx    = rdata0_q;
        rdata1_nx    = rdata1_q;

        case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    gnt_nx  = pick;
                    last_nx = pick;
                    we_nx   = sel_we;
                    if (!sel_ok) begin
                        // Out-of-range address: answer at once, RAM untouched.
                        state_nx = DONE;
                        ack0_nx  = ~pick;
                        ack1_nx  = pick;
                        err0_nx  = ~pick;
                        err1_nx  = pick;
                    end else begin
                        state_nx     = SETUP;
                        ram_addr_nx  = sel_addr;
                        ram_din_nx   = sel_we ? sel_wdata : '0;
                        ram_read_nx  = ~sel_we;
                        ram_write_nx = sel_we;
                    end
                end
            end
            SETUP: begin
                state_nx   = STROBE;
                cnt_nx     = 2'(ACCESS_CYCLES - 1);
                ram_ena_nx = 1'b0;
            end
            STROBE: begin
                if (cnt == 2'd0) begin
                    state_nx     = DONE;
                    ram_read_nx  = 1'b0;
                    ram_write_nx = 1'b0;
                    ack0_nx      = ~gnt;
                    ack1_nx      = gnt;
                    if (!we_q) begin
                        if (gnt) rdata1_nx = bus.ram_data;
                        else     rdata0_nx = bus.ram_data;
                    end
                end else begin
                    cnt_nx     = cnt - 2'd1;
                    ram_ena_nx = 1'b0;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the RAM immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            gnt         <= 1'b0;
            we_q        <= 1'b0;
            last_grant  <= 1'b1;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
            ram_ena_q   <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            gnt         <= gnt_nx;
            we_q        <= we_nx;
            last_grant  <= last_nx;
            ram_addr_q  <= ram_addr_nx;
            ram_din_q   <= ram_din_nx;
            ram_read_q  <= ram_read_nx;
            ram_write_q <= ram_write_nx;
            ram_ena_q   <= ram_ena_nx;
            ack0_q      <= ack0_nx;
            ack1_q      <= ack1_nx;
            err0_q      <= err0_nx;
            err1_q      <= err1_nx;
            rdata0_q    <= rdata0_nx;
            rdata1_q    <= rdata1_nx;
            busy_q      <= (state_nx != IDLE);
        end
    end

    // Drive the bus from the output flops.
    always_comb begin
        bus.ram_addr  = ram_addr_q;
        bus.ram_din   = ram_din_q;
        bus.ram_read  = ram_read_q;
        bus.ram_write = ram_write_q;
        bus.ram_ena   = ram_ena_q;
        bus.m0_ack    = ack0_q;
        bus.m1_ack    = ack1_q;
        bus.m0_err    = err0_q;
        bus.m1_err    = err1_q;
        bus.m0_rdata  = rdata0_q;
        bus.m1_rdata  = rdata1_q;
        bus.busy      = busy_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: one instance with ACCESS_CYCLES=1 (scoreboarded) and
// one with ACCESS_CYCLES=3, both fed the same requests, each with its own RAM.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_mem = 1'b1;
    always #5 clk = ~clk;

    logic       m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [5:0] m0_addr = '0, m1_addr = '0;
    logic [7:0] m0_wdata = '0, m1_wdata = '0;

    ram_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus1 ();
    ram_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus3 ();

    ram_arbiter #(.ADDR_W(6), .DATA_W(8), .DEPTH(4), .ACCESS_CYCLES(1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ram_arbiter #(.ADDR_W(6), .DATA_W(8), .DEPTH(4), .ACCESS_CYCLES(3))
        u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus1.m0_req = m0_req;   assign bus3.m0_req = m0_req;
    assign bus1.m0_we = m0_we;     assign bus3.m0_we = m0_we;
    assign bus1.m0_addr = m0_addr; assign bus3.m0_addr = m0_addr;
    assign bus1.m0_wdata = m0_wdata; assign bus3.m0_wdata = m0_wdata;
    assign bus1.m1_req = m1_req;   assign bus3.m1_req = m1_req;
    assign bus1.m1_we = m1_we;     assign bus3.m1_we = m1_we;
    assign bus1.m1_addr = m1_addr; assign bus3.m1_addr = m1_addr;
    assign bus1.m1_wdata = m1_wdata; assign bus3.m1_wdata = m1_wdata;

    // Behavioural level-sensitive RAMs; data only valid while enabled for read.
    logic [7:0] mem1 [4];
    logic [7:0] mem3 [4];
    assign bus1.ram_data = (!bus1.ram_ena && bus1.ram_read) ? mem1[bus1.ram_addr[1:0]] : 8'hEE;
    assign bus3.ram_data = (!bus3.ram_ena && bus3.ram_read) ? mem3[bus3.ram_addr[1:0]] : 8'hEE;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 4; i++) mem1[i] <= 8'hF0 + 8'(i);
        end else if (!bus1.ram_ena && bus1.ram_write) begin
            mem1[bus1.ram_addr[1:0]] <= bus1.ram_din;
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 4; i++) mem3[i] <= 8'hF0 + 8'(i);
        end else if (!bus3.ram_ena && bus3.ram_write) begin
            mem3[bus3.ram_addr[1:0]] <= bus3.ram_din;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: one entry per expected ack of the ACCESS_CYCLES=1 instance.
    typedef struct {
        bit         m;
        bit         err;
        logic [7:0] rd0;
        logic [7:0] rd1;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        bit         m;
        bit         we;
        logic [5:0] addr;
        logic [7:0] wdata;
        bit         exp_err;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t tbl [10];

    logic [7:0] mem_m [4];
    logic [7:0] rd_m [2];

    // Continuous monitor: invariants on both instances, acks against scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rw_exclusive_1", 32'(bus1.ram_read && bus1.ram_write), 32'd0);
            check("ena_only_busy_1", 32'(!bus1.ram_ena && !bus1.busy), 32'd0);
            check("acks_exclusive_1", 32'(bus1.m0_ack && bus1.m1_ack), 32'd0);
            check("rw_exclusive_3", 32'(bus3.ram_read && bus3.ram_write), 32'd0);
            check("acks_exclusive_3", 32'(bus3.m0_ack && bus3.m1_ack), 32'd0);
            if (bus1.m0_ack || bus1.m1_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_master", 32'(bus1.m1_ack), 32'(e.m));
                    check("ack_err", 32'(e.m ? bus1.m1_err : bus1.m0_err), 32'(e.err));
                    check("other_err", 32'(e.m ? bus1.m0_err : bus1.m1_err), 32'd0);
                    check("m0_rdata", 32'(bus1.m0_rdata), 32'(e.rd0));
                    check("m1_rdata", 32'(bus1.m1_rdata), 32'(e.rd1));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input bit m, input bit err);
        exp_t e;
        e.m = m; e.err = err; e.rd0 = rd_m[0]; e.rd1 = rd_m[1];
        sb.push_back(e);
    endtask

    task automatic drive(input bit m, input bit req, input bit we, input logic [5:0] addr, input logic [7:0] wdata);
        if (m) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    endtask

    task automatic do_txn(input vec_t v);
        bit got;
        got = 1'b0;
        if (!v.exp_err) begin
            if (v.we) mem_m[v.addr[1:0]] = v.wdata;
            else      rd_m[v.m] = v.exp_rdata;
        end
        push_exp(v.m, v.exp_err);
        @(negedge clk);
        drive(v.m, 1'b1, v.we, v.addr, v.wdata);
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (v.m ? bus1.m1_ack : bus1.m0_ack) got = 1'b1;
        end
        drive(v.m, 1'b0, 1'b0, 6'd0, 8'd0);
        check("txn_ack_seen", 32'(got), 32'd1);
    endtask

    task automatic contend(input logic [5:0] a0, input logic [5:0] a1, input int n);
        int acks;
        acks = 0;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = a0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = a1;
        for (int c = 0; c < 20 * n && acks < n; c++) begin
            @(negedge clk);
            if (bus1.m0_ack || bus1.m1_ack) acks++;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("contend_acks", 32'(acks), 32'(n));
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 6'd1,  8'h5A, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 6'd1,  8'h00, 1'b0, 8'h5A};
        tbl[2] = '{1'b1, 1'b0, 6'd9,  8'h00, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 6'd3,  8'h00, 1'b0, 8'hF3};
        tbl[4] = '{1'b0, 1'b1, 6'd0,  8'h3C, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 6'd0,  8'h00, 1'b0, 8'h3C};
        tbl[6] = '{1'b0, 1'b0, 6'd4,  8'h00, 1'b1, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 6'd63, 8'h00, 1'b1, 8'h00};
        tbl[8] = '{1'b1, 1'b1, 6'd9,  8'h11, 1'b1, 8'h00};
        tbl[9] = '{1'b0, 1'b0, 6'd3,  8'h00, 1'b0, 8'hF3};
        for (int i = 0; i < 4; i++) mem_m[i] = 8'hF0 + 8'(i);
        rd_m[0] = 8'h00; rd_m[1] = 8'h00;

        // Power-on reset values.
        repeat (2) @(negedge clk);
        check("rst_ena", 32'(bus1.ram_ena), 32'd1);
        check("rst_read", 32'(bus1.ram_read), 32'd0);
        check("rst_write", 32'(bus1.ram_write), 32'd0);
        check("rst_addr", 32'(bus1.ram_addr), 32'd0);
        check("rst_din", 32'(bus1.ram_din), 32'd0);
        check("rst_busy", 32'(bus1.busy), 32'd0);
        check("rst_acks", 32'({bus1.m0_ack, bus1.m1_ack, bus1.m0_err, bus1.m1_err}), 32'd0);
        load_mem = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // m0 read addr 2, cycle-by-cycle timing.
        rd_m[0] = 8'hF2;
        push_exp(1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 6'd2, 8'h00);
        @(negedge clk);
        check("c1_read", 32'(bus1.ram_read), 32'd1);
        check("c1_ena", 32'(bus1.ram_ena), 32'd1);
        check("c1_addr", 32'(bus1.ram_addr), 32'd2);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clk);
        check("c2_ena", 32'(bus1.ram_ena), 32'd0);
        check("c2_ack", 32'(bus1.m0_ack), 32'd0);
        @(negedge clk);
        check("c3_ack", 32'(bus1.m0_ack), 32'd1);
        check("c3_rdata", 32'(bus1.m0_rdata), 32'hF2);
        check("c3_err", 32'(bus1.m0_err), 32'd0);
        check("c3_ena", 32'(bus1.ram_ena), 32'd1);
        @(negedge clk);

        // Table-driven single-master transactions.
        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        // m1 rejected address: ack+err in cycle 1, RAM never enabled.
        push_exp(1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 6'd9, 8'h00);
        @(negedge clk);
        check("err_ack", 32'(bus1.m1_ack), 32'd1);
        check("err_err", 32'(bus1.m1_err), 32'd1);
        check("err_ena1", 32'(bus1.ram_ena), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clk);
        check("err_ena2", 32'(bus1.ram_ena), 32'd1);
        check("err_ack_once", 32'(bus1.m1_ack), 32'd0);
        check("err_idle", 32'(bus1.busy), 32'd0);

        // Both masters held high: strict alternation starting with m0.
        for (int k = 0; k < 2; k++) begin
            rd_m[0] = mem_m[0]; push_exp(1'b0, 1'b0);
            rd_m[1] = mem_m[2]; push_exp(1'b1, 1'b0);
        end
        contend(6'd0, 6'd2, 4);
        @(negedge clk);

        // Reset in the middle of an m0 write strobe.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 6'd0, 8'h77);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_strobe", 32'(bus1.ram_ena), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ena", 32'(bus1.ram_ena), 32'd1);
        check("arst_strobes", 32'({bus1.ram_read, bus1.ram_write}), 32'd0);
        check("arst_busy", 32'(bus1.busy), 32'd0);
        check("arst_acks", 32'({bus1.m0_ack, bus1.m1_ack}), 32'd0);
        check("arst_sb_empty", 32'(sb.size()), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        rd_m[0] = 8'h00; rd_m[1] = 8'h00;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check("ram_kept", 32'(mem1[i]), 32'(mem_m[i]));
        check("arst_rdata", 32'({bus1.m0_rdata, bus1.m1_rdata}), 32'd0);
        rst_n = 1'b1;

        // After reset m0 wins contention again.
        rd_m[0] = mem_m[1]; push_exp(1'b0, 1'b0);
        rd_m[1] = mem_m[3]; push_exp(1'b1, 1'b0);
        contend(6'd1, 6'd3, 2);

        // Wait for both instances to settle, then ACCESS_CYCLES=3 timing.
        begin
            bit idle;
            idle = 1'b0;
            for (int c = 0; c < 40 && !idle; c++) begin
                @(negedge clk);
                if (!bus1.busy && !bus3.busy) idle = 1'b1;
            end
            check("settle_idle", 32'(idle), 32'd1);
        end
        rd_m[0] = mem_m[3];
        push_exp(1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 6'd3, 8'h00);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
            check($sformatf("ac3_ena_c%0d", k), 32'(bus3.ram_ena), (k >= 2 && k <= 4) ? 32'd0 : 32'd1);
            check($sformatf("ac3_ack_c%0d", k), 32'(bus3.m0_ack), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check("ac3_rdata", 32'(bus3.m0_rdata), 32'hF3);
                check("ac3_err", 32'(bus3.m0_err), 32'd0);
            end
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
